// File: rtl/audio_mixer_sd.sv
// Multi-channel 8-bit audio mixer with timer/beeper term and delta-sigma DAC.
// Optional dither: define AUDIO_DITHER_EN to add LFSR noise before truncation.
module audio_mixer_sd #(
  parameter int NCH      = 6,
  parameter int MA_LOG2  = 2,
  parameter int CE_DIV   = 512,
  parameter int SD_WIDTH = 9,
  parameter int SD_DIV   = 8
) (
  input  logic             clk24,
  input  logic             reset_n,
  input  logic [3:0]       pulses,
  input  logic [8*NCH-1:0] ch_data,
  input  logic             gain_we,
  input  logic [3:0]       gain_addr,
  input  logic [7:0]       gain_data,
  output logic [15:0]      mix_l,
  output logic [15:0]      mix_r,
  output logic             sample_strobe,
  output logic [1:0]       clip,
  input  logic             clip_clr,
  output logic [1:0]       o_pwm
);

  localparam int CW  = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int D   = 1 << MA_LOG2;
  localparam int HW  = 3 * D;
  localparam int SDW = (SD_DIV > 1) ? $clog2(SD_DIV) : 1;
  localparam int TSH = 11 - MA_LOG2;

  typedef enum logic [1:0] {IDLE, ACC, SAT, OUT} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [HW-1:0]      hist_q, hist_d;
  logic [5:0]         sum_q, sum_d;
  logic [8*NCH-1:0]   sh_ch_q, sh_ch_d;
  logic [8*NCH-1:0]   gain_q, gain_d;
  logic [8*NCH-1:0]   sh_gain_q, sh_gain_d;
  logic [3:0]         idx_q, idx_d;
  logic [19:0]        acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [15:0]        mix_l_q, mix_l_d, mix_r_q, mix_r_d;
  logic               strobe_q, strobe_d;
  logic [1:0]         clip_q, clip_d;
  logic [SDW-1:0]     sd_cnt_q, sd_cnt_d;
  logic [SD_WIDTH:0]  accu_l_q, accu_l_d, accu_r_q, accu_r_d;
  logic [1:0]         pwm_q, pwm_d;

  logic               ce, load, acc_en, sat_en, sd_tick;
  logic [2:0]         t_now, oldest;
  logic [19:0]        timer;
  logic [7:0]         sel_ch, sel_g;
  logic [19:0]        prod_l, prod_r;
  logic               sat_l, sat_r;
  logic [SD_WIDTH-1:0] sd_top_l, sd_top_r;

`ifdef AUDIO_DITHER_EN
  localparam logic [16:0] DMASK = 17'((1 << (16 - SD_WIDTH)) - 1);
  logic [15:0] lfsr_q, lfsr_d;
  logic [16:0] dl, dr;
`endif

  assign ce            = (cnt_q == '0);
  assign mix_l         = mix_l_q;
  assign mix_r         = mix_r_q;
  assign sample_strobe = strobe_q;
  assign clip          = clip_q;
  assign o_pwm         = pwm_q;

  // Sequencer state register; reset aborts any sample in flight.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Sequencer next state: one ACC cycle per channel.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ce) state_d = ACC;
      ACC:     if (idx_q == 4'(NCH - 1)) state_d = SAT;
      SAT:     state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer controls.
  always_comb begin
    load   = 1'b0;
    acc_en = 1'b0;
    sat_en = 1'b0;
    case (state_q)
      IDLE:    load   = ce;
      ACC:     acc_en = 1'b1;
      SAT:     sat_en = 1'b1;
      default: ;
    endcase
  end

  // Sample timing, timer averaging, shadows, gain writes.
  always_comb begin
    cnt_d     = (cnt_q == CW'(CE_DIV - 1)) ? '0 : cnt_q + 1'b1;
    t_now     = 3'(pulses[0]) + 3'(pulses[1]) + 3'(pulses[2])
              + {1'b0, pulses[3], 1'b0};
    oldest    = hist_q[HW-1 -: 3];
    hist_d    = hist_q;
    sum_d     = sum_q;
    sh_ch_d   = sh_ch_q;
    sh_gain_d = sh_gain_q;
    if (ce) begin
      hist_d    = HW'({hist_q, t_now});
      sum_d     = sum_q + {3'b0, t_now} - {3'b0, oldest};
      sh_ch_d   = ch_data;
      sh_gain_d = gain_q;
    end
    timer  = 20'(sum_d) << TSH;
    gain_d = gain_q;
    for (int k = 0; k < NCH; k++) begin
      if (gain_we && gain_addr == 4'(k)) gain_d[8*k +: 8] = gain_data;
    end
  end

  // Mix datapath: preload, accumulate, clamp, publish.
  always_comb begin
    sel_ch = '0;
    sel_g  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx_q == 4'(k)) begin
        sel_ch = sh_ch_q[8*k +: 8];
        sel_g  = sh_gain_q[8*k +: 8];
      end
    end
    prod_l = ({12'b0, sel_ch} * {16'b0, sel_g[3:0]}) << 3;
    prod_r = ({12'b0, sel_ch} * {16'b0, sel_g[7:4]}) << 3;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    if (load) begin
      acc_l_d = timer;
      acc_r_d = timer;
    end else if (acc_en) begin
      acc_l_d = acc_l_q + prod_l;
      acc_r_d = acc_r_q + prod_r;
    end
    idx_d    = acc_en ? idx_q + 4'd1 : 4'd0;
    sat_l    = acc_l_q > 20'd65535;
    sat_r    = acc_r_q > 20'd65535;
    mix_l_d  = mix_l_q;
    mix_r_d  = mix_r_q;
    strobe_d = 1'b0;
    if (sat_en) begin
      mix_l_d  = sat_l ? 16'hFFFF : acc_l_q[15:0];
      mix_r_d  = sat_r ? 16'hFFFF : acc_r_q[15:0];
      strobe_d = 1'b1;
    end
    clip_d = (clip_clr ? 2'b00 : clip_q)
           | (sat_en ? {sat_r, sat_l} : 2'b00);
  end

  // First-order delta-sigma modulators, one per side.
  always_comb begin
    sd_tick  = (sd_cnt_q == SDW'(SD_DIV - 1));
    sd_cnt_d = sd_tick ? '0 : sd_cnt_q + 1'b1;
`ifdef AUDIO_DITHER_EN
    lfsr_d   = sd_tick ? {lfsr_q[14:0],
                          lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]}
                       : lfsr_q;
    dl       = {1'b0, mix_l_q} + (17'(lfsr_q) & DMASK);
    dr       = {1'b0, mix_r_q} + (17'(lfsr_q) & DMASK);
    sd_top_l = dl[16] ? {SD_WIDTH{1'b1}} : dl[15 -: SD_WIDTH];
    sd_top_r = dr[16] ? {SD_WIDTH{1'b1}} : dr[15 -: SD_WIDTH];
`else
    sd_top_l = mix_l_q[15 -: SD_WIDTH];
    sd_top_r = mix_r_q[15 -: SD_WIDTH];
`endif
    accu_l_d = accu_l_q;
    accu_r_d = accu_r_q;
    pwm_d    = pwm_q;
    if (sd_tick) begin
      accu_l_d = {1'b0, accu_l_q[SD_WIDTH-1:0]} + {1'b0, sd_top_l};
      accu_r_d = {1'b0, accu_r_q[SD_WIDTH-1:0]} + {1'b0, sd_top_r};
      pwm_d    = {accu_r_d[SD_WIDTH], accu_l_d[SD_WIDTH]};
    end
  end

  // Datapath registers.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      hist_q    <= '0;
      sum_q     <= '0;
      sh_ch_q   <= '0;
      gain_q    <= {NCH{8'h88}};
      sh_gain_q <= {NCH{8'h88}};
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      mix_l_q   <= '0;
      mix_r_q   <= '0;
      strobe_q  <= 1'b0;
      clip_q    <= '0;
      sd_cnt_q  <= '0;
      accu_l_q  <= '0;
      accu_r_q  <= '0;
      pwm_q     <= '0;
`ifdef AUDIO_DITHER_EN
      lfsr_q    <= 16'h0001;
`endif
    end else begin
      cnt_q     <= cnt_d;
      hist_q    <= hist_d;
      sum_q     <= sum_d;
      sh_ch_q   <= sh_ch_d;
      gain_q    <= gain_d;
      sh_gain_q <= sh_gain_d;
      idx_q     <= idx_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      mix_l_q   <= mix_l_d;
      mix_r_q   <= mix_r_d;
      strobe_q  <= strobe_d;
      clip_q    <= clip_d;
      sd_cnt_q  <= sd_cnt_d;
      accu_l_q  <= accu_l_d;
      accu_r_q  <= accu_r_d;
      pwm_q     <= pwm_d;
`ifdef AUDIO_DITHER_EN
      lfsr_q    <= lfsr_d;
`endif
    end
  end

endmodule

// File: tb/tb_audio_mixer_sd.sv
// Bench for audio_mixer_sd: directed + random samples vs. arithmetic model.
// Covers reset, latency, gains, clipping, timer averaging, delta-sigma.
module tb_audio_mixer_sd;

  localparam int NCH = 6;
  localparam int MA  = 2;
  localparam int CED = 32;
  localparam int SDW = 9;
  localparam int SDD = 8;

  logic             clk24 = 1'b0;
  logic             reset_n = 1'b1;
  logic [3:0]       pulses = '0;
  logic [8*NCH-1:0] ch_data = '0;
  logic             gain_we = 1'b0;
  logic [3:0]       gain_addr = '0;
  logic [7:0]       gain_data = '0;
  logic             clip_clr = 1'b0;
  logic [15:0]      mix_l, mix_r;
  logic             sample_strobe;
  logic [1:0]       clip, o_pwm;

  audio_mixer_sd #(
    .NCH(NCH), .MA_LOG2(MA), .CE_DIV(CED),
    .SD_WIDTH(SDW), .SD_DIV(SDD)
  ) dut (
    .clk24(clk24), .reset_n(reset_n), .pulses(pulses),
    .ch_data(ch_data), .gain_we(gain_we), .gain_addr(gain_addr),
    .gain_data(gain_data), .mix_l(mix_l), .mix_r(mix_r),
    .sample_strobe(sample_strobe), .clip(clip),
    .clip_clr(clip_clr), .o_pwm(o_pwm)
  );

  always #5 clk24 = ~clk24;

  int total = 0;
  int bad = 0;

  logic [7:0] chm[NCH];
  logic [3:0] glm[NCH];
  logic [3:0] grm[NCH];
  int         hq[$];
  logic [1:0] clipm;
  int         expl, expr;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hq.delete();
    clipm = 2'b00;
    for (int k = 0; k < NCH; k++) begin
      glm[k] = 4'h8;
      grm[k] = 4'h8;
    end
  endtask

  task automatic apply_ch();
    for (int k = 0; k < NCH; k++) ch_data[8*k +: 8] = chm[k];
  endtask

  task automatic wr_gain(input logic [3:0] a, input logic [7:0] d);
    int ai;
    gain_we = 1'b1;
    gain_addr = a;
    gain_data = d;
    @(posedge clk24);
    #1;
    gain_we = 1'b0;
    ai = int'(a);
    if (ai < NCH) begin
      glm[ai] = d[3:0];
      grm[ai] = d[7:4];
    end
  endtask

  task automatic model_sample();
    int t, s, l, r;
    t = int'(pulses[0]) + int'(pulses[1]) + int'(pulses[2])
      + 2 * int'(pulses[3]);
    hq.push_back(t);
    if (hq.size() > (1 << MA)) void'(hq.pop_front());
    s = 0;
    foreach (hq[i]) s += hq[i];
    l = s * (1 << (11 - MA));
    r = l;
    for (int k = 0; k < NCH; k++) begin
      l += int'(chm[k]) * int'(glm[k]) * 8;
      r += int'(chm[k]) * int'(grm[k]) * 8;
    end
    if (l > 65535) begin l = 65535; clipm[0] = 1'b1; end
    if (r > 65535) begin r = 65535; clipm[1] = 1'b1; end
    expl = l;
    expr = r;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(posedge clk24);
      #1;
      n++;
    end while (!sample_strobe && n < 4 * CED);
  endtask

  task automatic wait_check(string tag, int exp_n);
    int n;
    wait_strobe(n);
    check({tag, "_seen"}, 32'(sample_strobe), 1);
    if (exp_n > 0) check({tag, "_lat"}, n, exp_n);
    check({tag, "_l"}, 32'(mix_l), expl);
    check({tag, "_r"}, 32'(mix_r), expr);
    check({tag, "_clip"}, 32'(clip), 32'(clipm));
  endtask

  task automatic do_sample(string tag, int exp_n);
    model_sample();
    wait_check(tag, exp_n);
  endtask

  task automatic do_reset(string tag);
    reset_n = 1'b0;
    #1;
    check({tag, "_mixl"}, 32'(mix_l), 0);
    check({tag, "_mixr"}, 32'(mix_r), 0);
    check({tag, "_clip"}, 32'(clip), 0);
    check({tag, "_pwm"}, 32'(o_pwm), 0);
    check({tag, "_stb"}, 32'(sample_strobe), 0);
    model_reset();
    repeat (2) @(posedge clk24);
    @(negedge clk24);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lit[5];
    int   ones;
    logic prev, expb;
    lit = '{1024, 2048, 3072, 4096, 4096};
    for (int k = 0; k < NCH; k++) chm[k] = '0;
    model_reset();
    #1;
    do_reset("rst0");

    do_sample("idle0", 8);

    wr_gain(4'd0, 8'h0F);
    for (int k = 1; k < NCH; k++) wr_gain(4'(k), 8'h00);
    chm[0] = 8'd255;
    apply_ch();
    do_sample("one_ch", 0);
    check("one_ch_lit_l", 32'(mix_l), 30600);
    check("one_ch_lit_r", 32'(mix_r), 0);
    @(posedge clk24);
    #1;
    check("strobe_1cyc", 32'(sample_strobe), 0);

    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < NCH; k++) chm[k] = 8'($urandom_range(0, 255));
      apply_ch();
      pulses = 4'($urandom_range(0, 15));
      repeat (3) wr_gain(4'($urandom_range(0, 7)), 8'($urandom));
      if (it % 4 == 3) begin
        clip_clr = 1'b1;
        @(posedge clk24);
        #1;
        clip_clr = 1'b0;
        clipm = 2'b00;
        check("rand_clr", 32'(clip), 0);
      end
      do_sample("rand", 0);
    end
    do_sample("period", CED);

    pulses = 4'd0;
    for (int k = 0; k < NCH; k++) chm[k] = 8'd255;
    apply_ch();
    for (int k = 0; k < NCH; k++) wr_gain(4'(k), 8'hFF);
    do_sample("full", 0);
    check("full_lit_l", 32'(mix_l), 65535);
    check("full_lit_clip", 32'(clip), 3);
    for (int k = 0; k < NCH; k++) chm[k] = 8'd1;
    apply_ch();
    clip_clr = 1'b1;
    @(posedge clk24);
    #1;
    clip_clr = 1'b0;
    clipm = 2'b00;
    check("clr_now", 32'(clip), 0);
    do_sample("low", 0);
    check("low_lit_clip", 32'(clip), 0);
    for (int k = 0; k < NCH; k++) chm[k] = 8'd255;
    apply_ch();
    clip_clr = 1'b1;
    clipm = 2'b00;
    do_sample("setwins", 0);
    clip_clr = 1'b0;
    @(posedge clk24);
    #1;
    check("setwins_hold", 32'(clip), 3);

    for (int k = 0; k < NCH; k++) chm[k] = '0;
    chm[0] = 8'd100;
    apply_ch();
    wr_gain(4'd0, 8'h21);
    do_sample("pre_acc", 0);
    model_sample();
    repeat (27) @(posedge clk24);
    #1;
    gain_we = 1'b1;
    gain_addr = 4'd0;
    gain_data = 8'h5A;
    @(posedge clk24);
    #1;
    gain_we = 1'b0;
    wait_check("acc_wr", 4);
    check("acc_wr_lit_l", 32'(mix_l), 800);
    check("acc_wr_lit_r", 32'(mix_r), 1600);
    glm[0] = 4'hA;
    grm[0] = 4'h5;
    wr_gain(4'd6, 8'hFF);
    wr_gain(4'd14, 8'hFF);
    do_sample("post_acc", 0);
    check("post_acc_lit_l", 32'(mix_l), 8000);
    check("post_acc_lit_r", 32'(mix_r), 4000);

    do_reset("rst1");
    pulses = 4'b1000;
    for (int k = 0; k < NCH; k++) chm[k] = '0;
    apply_ch();
    for (int i = 0; i < 5; i++) begin
      model_sample();
      wait_check("tmr", (i == 0) ? 8 : CED);
      check("tmr_lit_l", 32'(mix_l), lit[i]);
      check("tmr_lit_r", 32'(mix_r), lit[i]);
    end

    do_reset("rst2");
    pulses = 4'd0;
    chm[0] = 8'd255;
    chm[1] = 8'd255;
    chm[2] = 8'd16;
    apply_ch();
    do_sample("pw0", 8);
    wr_gain(4'd0, 8'h0F);
    wr_gain(4'd1, 8'h01);
    wr_gain(4'd2, 8'h01);
    for (int k = 3; k < NCH; k++) wr_gain(4'(k), 8'h00);
    do_sample("pw1", 0);
    check("pw1_lit_l", 32'(mix_l), 32768);
    repeat (16) @(posedge clk24);
    #1;
    prev = o_pwm[0];
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      repeat (SDD) @(posedge clk24);
      #1;
      expb = ~prev;
      check("pwm_alt", 32'(o_pwm[0]), 32'(expb));
      check("pwm_r0", 32'(o_pwm[1]), 0);
      ones += int'(o_pwm[0]);
      prev = o_pwm[0];
    end
    check("pwm_duty", ones, 8);
    do_sample("pw2", 0);

    repeat (27) @(posedge clk24);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_mixl", 32'(mix_l), 0);
    check("midrst_mixr", 32'(mix_r), 0);
    check("midrst_clip", 32'(clip), 0);
    check("midrst_pwm", 32'(o_pwm), 0);
    check("midrst_stb", 32'(sample_strobe), 0);
    model_reset();
    repeat (2) @(posedge clk24);
    @(negedge clk24);
    reset_n = 1'b1;
    for (int k = 0; k < NCH; k++) chm[k] = '0;
    chm[0] = 8'd10;
    apply_ch();
    do_sample("after_rst", 8);
    check("after_rst_lit", 32'(mix_l), 640);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
